fifo_write_pointer_full: RTL and testbench

//   Write-domain pointer and full-flag controller for the asynchronous FIFO; the write-side

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/fifo_gray_to_binary.sv | 20 ++
 rtl/fifo_write_pointer_full.sv | 101 ++++++++++
 tb/tb_fifo_write_pointer_full.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer controllers.
//   fifo_addr_width   : RAM address width for a given depth
//   fifo_params_valid : depth is a power of 2 (>= 4) and threshold lies in 1..depth
//   fifo_bin_to_gray  : binary -> reflected Gray (up to 32 bits, zero-extend narrower values)
//   fifo_gray_to_bin  : reflected Gray -> binary (up to 32 bits)
package fifo_pkg;

    localparam int unsigned FifoMaxWidth = 32;

    function automatic int unsigned fifo_addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit fifo_is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifo_params_valid(input int unsigned depth,
                                             input int unsigned threshold);
        return fifo_is_pow2(depth) && (depth >= 4) && (threshold >= 1) && (threshold <= depth);
    endfunction

    function automatic logic [FifoMaxWidth-1:0] fifo_bin_to_gray(
        input logic [FifoMaxWidth-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FifoMaxWidth-1:0] fifo_gray_to_bin(
        input logic [FifoMaxWidth-1:0] gray
    );
        logic [FifoMaxWidth-1:0] bin;
        bin = '0;
        for (int i = 0; i < FifoMaxWidth; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_to_binary.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write-side full controller and the read-side empty controller.
//   gray   in  WIDTH  reflected Gray code
//   binary out WIDTH  equivalent binary value
module fifo_gray_to_binary #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    // Bit i of the binary value is the XOR of all Gray bits at and above i.
    always_comb begin
        binary = '0;
        for (int i = 0; i < WIDTH; i++) begin
            binary[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_write_pointer_full.sv
// Write-domain pointer and full-flag controller of the asynchronous FIFO.
// Holds binary and Gray write pointers, drives the RAM write address and registers
// full, almost-full, fill level and a sticky overflow flag.
//   write_clock        in   1     write-domain clock
//   write_reset_n      in   1     asynchronous active-low reset
//   write_enable       in   1     push request, ignored while fifo_full
//   overflow_clear     in   1     clears the sticky overflow flag
//   sync_read_pointer  in   AW+1  Gray read pointer, already synchronized to write_clock
//   fifo_full          out  1     registered full flag
//   fifo_almost_full   out  1     registered level >= ALMOST_FULL_THRESHOLD
//   write_address      out  AW    RAM write address (pre-increment binary pointer)
//   write_pointer      out  AW+1  registered Gray write pointer for the read-side synchronizer
//   write_level        out  AW+1  registered fill level 0..DEPTH (never under-reports)
//   overflow           out  1     sticky: a write was attempted while full
module fifo_write_pointer_full
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH                 = 16,
    parameter int unsigned ALMOST_FULL_THRESHOLD = 12,
    localparam int unsigned AW                   = fifo_addr_width(DEPTH),
    localparam int unsigned PW                   = AW + 1
) (
    input  logic          write_clock,
    input  logic          write_reset_n,
    input  logic          write_enable,
    input  logic          overflow_clear,
    input  logic [PW-1:0] sync_read_pointer,
    output logic          fifo_full,
    output logic          fifo_almost_full,
    output logic [AW-1:0] write_address,
    output logic [PW-1:0] write_pointer,
    output logic [PW-1:0] write_level,
    output logic          overflow
);

    if (!fifo_params_valid(DEPTH, ALMOST_FULL_THRESHOLD)) begin : g_param_check
        $error("fifo_write_pointer_full: DEPTH must be a power of 2 >= 4, threshold 1..DEPTH");
    end

    localparam logic [PW-1:0] AlmostFullLevel = PW'(ALMOST_FULL_THRESHOLD);

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic [PW-1:0] read_bin;
    logic [PW-1:0] full_gray;

    fifo_gray_to_binary #(
        .WIDTH (PW)
    ) u_read_gray_to_binary (
        .gray   (sync_read_pointer),
        .binary (read_bin)
    );

    // Full when the write pointer is exactly one lap ahead: in Gray code that is the
    // read pointer with its two MSBs inverted, which stays glitch-free across the wrap.
    assign full_gray = {~sync_read_pointer[PW-1:PW-2], sync_read_pointer[PW-3:0]};

    always_comb begin
        push          = write_enable & ~full_q;
        bin_d         = bin_q + {{AW{1'b0}}, push};
        gray_d        = PW'(fifo_bin_to_gray(FifoMaxWidth'(bin_d)));
        full_d        = (gray_d == full_gray);
        // A stale read pointer can only overstate the level, never understate it.
        level_d       = bin_d - read_bin;
        almost_full_d = (level_d >= AlmostFullLevel);
        // Setting wins over clearing so a rejected push is never lost.
        overflow_d    = (overflow_q & ~overflow_clear) | (write_enable & full_q);
    end

    always_ff @(posedge write_clock or negedge write_reset_n) begin
        if (!write_reset_n) begin
            bin_q         <= '0;
            gray_q        <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            bin_q         <= bin_d;
            gray_q        <= gray_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fifo_full        = full_q;
    assign fifo_almost_full = almost_full_q;
    assign write_address    = bin_q[AW-1:0];
    assign write_pointer    = gray_q;
    assign write_level      = level_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_fifo_write_pointer_full.sv
module tb_fifo_write_pointer_full;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned THR   = 12;

    logic       write_clock = 1'b0;
    logic       write_reset_n;
    logic       write_enable;
    logic       overflow_clear;
    logic [4:0] sync_read_pointer;
    logic       fifo_full;
    logic       fifo_almost_full;
    logic [3:0] write_address;
    logic [4:0] write_pointer;
    logic [4:0] write_level;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;

    fifo_write_pointer_full #(
        .DEPTH                 (DEPTH),
        .ALMOST_FULL_THRESHOLD (THR)
    ) dut (
        .write_clock       (write_clock),
        .write_reset_n     (write_reset_n),
        .write_enable      (write_enable),
        .overflow_clear    (overflow_clear),
        .sync_read_pointer (sync_read_pointer),
        .fifo_full         (fifo_full),
        .fifo_almost_full  (fifo_almost_full),
        .write_address     (write_address),
        .write_pointer     (write_pointer),
        .write_level       (write_level),
        .overflow          (overflow)
    );

    always #5 write_clock = ~write_clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge write_clock);
        #1;
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic do_reset();
        write_reset_n = 1'b0;
        step();
        step();
        write_reset_n = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_full"},   32'(fifo_full),        0);
        check({tag, "_afull"},  32'(fifo_almost_full), 0);
        check({tag, "_addr"},   32'(write_address),    0);
        check({tag, "_wptr"},   32'(write_pointer),    0);
        check({tag, "_level"},  32'(write_level),      0);
        check({tag, "_ovf"},    32'(overflow),         0);
    endtask

    logic [4:0] m_bin, m_rbin, m_level, nb, prev_wptr, diff;
    logic       m_full, m_ovf, push;
    int         accepted, cycles;

    initial begin
        write_reset_n     = 1'b0;
        write_enable      = 1'b0;
        overflow_clear    = 1'b0;
        sync_read_pointer = 5'd0;
        #3;
        check_all_zero("reset");
        do_reset();
        check_all_zero("post_reset");

        // Fill 16 entries with the read pointer parked at 0.
        write_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fill_addr", 32'(write_address), 32'(i));
            check("fill_notfull", 32'(fifo_full), 0);
            step();
            check("fill_level", 32'(write_level), 32'(i + 1));
            check("fill_afull", 32'(fifo_almost_full), (i + 1 >= 12) ? 1 : 0);
        end
        check("full_set", 32'(fifo_full), 1);
        check("full_wptr", 32'(write_pointer), 32'b11000);
        check("full_addr", 32'(write_address), 0);

        // Pushes while full are rejected and flagged.
        for (int i = 0; i < 3; i++) begin
            step();
            check("ovf_wptr", 32'(write_pointer), 32'b11000);
            check("ovf_level", 32'(write_level), 16);
            check("ovf_flag", 32'(overflow), 1);
            check("ovf_full", 32'(fifo_full), 1);
        end
        write_enable = 1'b0;
        step();
        step();
        check("ovf_sticky", 32'(overflow), 1);
        write_enable   = 1'b1;
        overflow_clear = 1'b1;
        step();
        check("ovf_set_wins", 32'(overflow), 1);
        write_enable = 1'b0;
        step();
        check("ovf_cleared", 32'(overflow), 0);
        overflow_clear = 1'b0;

        // One read frees a slot, one write fills it again.
        sync_read_pointer = 5'b00001;
        step();
        check("rd_notfull", 32'(fifo_full), 0);
        check("rd_level", 32'(write_level), 15);
        write_enable = 1'b1;
        step();
        check("refull", 32'(fifo_full), 1);
        check("refull_level", 32'(write_level), 16);
        check("refull_wptr", 32'(write_pointer), 32'b11001);
        write_enable = 1'b0;

        // Almost-full threshold crossing (write bin 17).
        sync_read_pointer = 5'd5;  // Gray of 6 -> level 11
        step();
        check("af_l11_level", 32'(write_level), 11);
        check("af_l11_flag", 32'(fifo_almost_full), 0);
        check("af_l11_full", 32'(fifo_full), 0);
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        check("af_l12_level", 32'(write_level), 12);
        check("af_l12_flag", 32'(fifo_almost_full), 1);
        sync_read_pointer = 5'd4;  // Gray of 7 -> level 11
        step();
        check("af_drop_level", 32'(write_level), 11);
        check("af_drop_flag", 32'(fifo_almost_full), 0);

        // Random push / read traffic over 100 laps of the 32-entry pointer space.
        sync_read_pointer = 5'd0;
        do_reset();
        m_bin = 0; m_rbin = 0; m_full = 0; m_ovf = 0;
        accepted = 0; cycles = 0;
        prev_wptr = write_pointer;
        while (accepted < 3200 && cycles < 20000) begin
            write_enable   = ($urandom_range(3) != 0);
            overflow_clear = ($urandom_range(15) == 0);
            if (m_rbin != m_bin && $urandom_range(2) != 0) m_rbin = m_rbin + 5'd1;
            sync_read_pointer = to_gray(m_rbin);
            push    = write_enable & ~m_full;
            m_ovf   = (m_ovf & ~overflow_clear) | (write_enable & m_full);
            nb      = m_bin + {4'd0, push};
            m_level = nb - m_rbin;
            m_full  = (m_level == 5'd16);
            m_bin   = nb;
            if (push) accepted++;
            step();
            cycles++;
            check("rnd_level", 32'(write_level), 32'(m_level));
            check("rnd_full", 32'(fifo_full), 32'(m_full));
            check("rnd_afull", 32'(fifo_almost_full), (m_level >= 5'd12) ? 1 : 0);
            check("rnd_wptr", 32'(write_pointer), 32'(to_gray(m_bin)));
            check("rnd_addr", 32'(write_address), 32'(m_bin[3:0]));
            check("rnd_ovf", 32'(overflow), 32'(m_ovf));
            diff = write_pointer ^ prev_wptr;
            check("rnd_onebit", ($countones(diff) <= 1) ? 1 : 0, 1);
            prev_wptr = write_pointer;
        end
        check("rnd_laps_done", (accepted >= 3200) ? 1 : 0, 1);

        // Asynchronous reset in the middle of a burst.
        overflow_clear = 1'b0;
        write_enable   = 1'b1;
        sync_read_pointer = 5'd0;
        step();
        step();
        #2;
        write_reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        write_enable = 1'b0;
        step();
        write_reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
